fp_int2float_pipe: RTL and testbench

Parametrised, pipelined integer to DLfloat16 converter (1 sign, 6 exponent, 9 mantissa bits, bias 31) with selectable signed or unsigned input and selectable rounding. It replaces the single-register integer converter in the FPU datapath. It adds a valid/ready handshake, round-to-nearest-even, correct IEEE-style exception flags and overflow saturation. It sits between the integer operand bus and the FPU result mux.

---
 rtl/fp_int2float_pipe.sv | 141 ++++++++++++++
 tb/tb_fp_int2float_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_int2float_pipe.sv
// Integer to DLfloat16 (1/6/9, bias 31) converter: three-stage pipeline with
// valid/ready handshake, signed/unsigned input, RNE/RTZ rounding, overflow
// saturation and exception flags {invalid, inexact, overflow, underflow, div_by_zero}.
module fp_int2float_pipe #(
    parameter int IN_W  = 32,
    parameter int EXP_W = 6,
    parameter int MAN_W = 9,
    parameter int BIAS  = 31
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_int,
    input  logic                   is_signed,
    input  logic                   rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   float_out,
    output logic [4:0]             exceptions
);

    localparam int STAGES = 3;
    localparam int PW     = $clog2(IN_W);
    // fraction below the hidden one, padded so MAN_W + guard + sticky always exist
    localparam int FW     = IN_W - 1 + MAN_W + 2;
    // biased exponent is wide enough to see overflow without truncation
    localparam int EW     = ((EXP_W > PW) ? EXP_W : PW) + 2;

    logic [STAGES:1] vld_pipe;
    logic            advance;

    // S1 registers
    logic            sign1, rnd1;
    logic [IN_W-1:0] abs1;

    // S2 registers
    logic             sign2, rnd2, zero2, guard2, sticky2;
    logic [PW-1:0]    p2;
    logic [MAN_W-1:0] man2;

    // S2 combinational
    logic [PW-1:0]    lz_p, shamt;
    logic [IN_W-1:0]  norm;
    logic [FW-1:0]    ext;

    // S3 combinational
    logic             rnd_up, carry, ovf, inexact;
    logic [MAN_W:0]   man_inc;
    logic [EW-1:0]    exp_b;
    logic [EXP_W+MAN_W:0] res;
    logic [4:0]       exc;

    // whole pipe moves as one unit; a stalled output freezes every stage
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];

    // valid shift register
    always_ff @(posedge clk) begin
        if (rst)
            vld_pipe <= '0;
        else if (advance)
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // S1: sign and magnitude; the signed minimum wraps to exactly 2^(IN_W-1)
    always_ff @(posedge clk) begin
        if (rst) begin
            sign1 <= 1'b0;
            rnd1  <= 1'b0;
            abs1  <= '0;
        end else if (advance && in_valid) begin
            sign1 <= is_signed & in_int[IN_W-1];
            rnd1  <= rnd_mode;
            abs1  <= (is_signed & in_int[IN_W-1]) ? (~in_int + IN_W'(1)) : in_int;
        end
    end

    // leading-one position (highest set bit wins)
    always_comb begin
        lz_p = '0;
        for (int i = 0; i < IN_W; i++)
            if (abs1[i]) lz_p = PW'(i);
    end

    assign shamt = PW'(IN_W - 1) - lz_p;
    assign norm  = abs1 << shamt;
    assign ext   = {norm[IN_W-2:0], {(MAN_W+2){1'b0}}};

    // S2: normalise; a zero operand never gets a leading one to the top
    always_ff @(posedge clk) begin
        if (rst) begin
            sign2   <= 1'b0;
            rnd2    <= 1'b0;
            zero2   <= 1'b0;
            p2      <= '0;
            man2    <= '0;
            guard2  <= 1'b0;
            sticky2 <= 1'b0;
        end else if (advance && vld_pipe[1]) begin
            sign2   <= sign1;
            rnd2    <= rnd1;
            zero2   <= ~norm[IN_W-1];
            p2      <= lz_p;
            man2    <= ext[FW-1 -: MAN_W];
            guard2  <= ext[FW-1-MAN_W];
            sticky2 <= |ext[FW-2-MAN_W:0];
        end
    end

    // round, detect overflow against the reserved all-ones exponent, pack
    always_comb begin
        rnd_up  = !rnd2 && guard2 && (sticky2 || man2[0]);
        man_inc = {1'b0, man2} + (MAN_W+1)'(rnd_up);
        carry   = man_inc[MAN_W];
        exp_b   = EW'(p2) + EW'(BIAS) + EW'(carry);
        ovf     = exp_b >= EW'((1 << EXP_W) - 1);
        inexact = guard2 | sticky2 | ovf;
        res     = {sign2, exp_b[EXP_W-1:0], man_inc[MAN_W-1:0]};
        exc     = {1'b0, inexact, ovf, 2'b00};
        if (zero2) begin
            res = '0;
            exc = '0;
        end else if (ovf) begin
            res = {sign2, EXP_W'((1 << EXP_W) - 2), {MAN_W{1'b1}}};
        end
    end

    // S3: output register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            float_out  <= '0;
            exceptions <= '0;
        end else if (advance && vld_pipe[2]) begin
            float_out  <= res;
            exceptions <= exc;
        end
    end

endmodule

// File: tb/tb_fp_int2float_pipe.sv
// Bench for fp_int2float_pipe: directed vectors pinned by literals, an
// arithmetic reference model feeding a scoreboard, and handshake/reset scenarios.
module tb_fp_int2float_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, is_signed, rnd_mode, out_valid, out_ready;
    logic [31:0] in_int;
    logic [15:0] float_out;
    logic [4:0]  exceptions;

    int checks = 0;
    int errors = 0;

    logic [20:0] sb[$];
    logic        held = 1'b0;
    logic [20:0] held_val;

    fp_int2float_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_int(in_int), .is_signed(is_signed), .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .float_out(float_out), .exceptions(exceptions)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: value = mag / 2^p scaled by 2^9 as quotient + remainder,
    // rounded with exact remainder comparison. Returns {float[15:0], exc[4:0]}.
    function automatic logic [20:0] model(input logic [31:0] x, input logic s, input logic r);
        longint unsigned mag, q, rem, pw;
        int p, e;
        logic sg;
        sg  = s & x[31];
        mag = sg ? (64'h1_0000_0000 - {32'h0, x}) : {32'h0, x};
        if (mag == 0) return '0;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        pw  = 64'd1 << p;
        q   = (mag << 9) / pw;
        rem = (mag << 9) % pw;
        if (!r && ((2 * rem > pw) || (2 * rem == pw && q[0]))) q++;
        if (q == 1024) begin
            q = 512;
            p++;
        end
        e = p + 31;
        if (e >= 63) return {sg, 6'd62, 9'h1FF, 5'b01100};
        return {sg, 6'(e), q[8:0], 1'b0, (rem != 0), 3'b000};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] specials [6] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF,
                                      32'h7FFF_FFFF, 32'd2047, 32'd1025};
        case ($urandom % 4)
            0: return $urandom;
            1: return 32'($urandom_range(0, 4095));
            2: return 32'h0 - 32'($urandom_range(1, 70000));
            default: return specials[$urandom % 6];
        endcase
    endfunction

    // scoreboard: push on input transfer, pop/compare on output transfer,
    // and require the output to hold while stalled
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'({float_out, exceptions}), 32'(held_val));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %h expected no output", {float_out, exceptions});
                end else begin
                    logic [20:0] e;
                    e = sb.pop_front();
                    chk("result", 32'({float_out, exceptions}), 32'(e));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_int, is_signed, rnd_mode));
            held     = out_valid && !out_ready;
            held_val = {float_out, exceptions};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] x, input logic s, input logic r);
        int c = 0;
        in_valid = 1'b1; in_int = x; is_signed = s; rnd_mode = r;
        #1;
        while (!in_ready && c < 100) begin
            tick();
            c++;
        end
        if (c >= 100) begin
            checks++; errors++;
            $display("FAIL push_timeout: got in_ready low for %0d cycles expected accept", c);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        while (sb.size() != 0 && c < 50) begin
            tick();
            c++;
        end
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    logic [31:0] vx [11] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd1023, 32'h8000_0000,
                             32'd1025, 32'd1027, 32'd1027, 32'd2047, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic        vs [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic        vr [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    logic [15:0] vf [11] = '{16'h0000, 16'h3E00, 16'hBE00, 16'h51FF, 16'hFC00,
                             16'h5200, 16'h5202, 16'h5201, 16'h5400, 16'h7DFF, 16'h7DFF};
    logic [4:0]  ve [11] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                             5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01100, 5'b01000};

    initial begin
        int acc, sent, cyc;
        logic pending;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_int = '0; is_signed = 1'b1; rnd_mode = 1'b0;
        tick(); tick();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_float", 32'(float_out), 32'd0);
        chk("reset_exc", 32'(exceptions), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // directed vectors: model pinned to literals, DUT checked by scoreboard
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("lit_%0d", i), 32'(model(vx[i], vs[i], vr[i])), 32'({vf[i], ve[i]}));
            push(vx[i], vs[i], vr[i]);
        end
        drain();

        // latency and throughput: 100 back-to-back operands
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_int = rand_operand();
            is_signed = 1'($urandom % 2); rnd_mode = 1'($urandom % 2);
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'(i >= 2));
        end
        drain();

        // backpressure: three accepted, then in_ready drops and output holds
        out_ready = 1'b0; acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_int = 32'(100 + 37 * i); is_signed = 1'b1; rnd_mode = 1'b0;
            #1;
            if (in_ready) acc++;
            tick();
        end
        chk("bp_accepted", 32'(acc), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();

        // random handshake, 10k items
        sent = 0; cyc = 0; pending = 1'b0;
        while (sent < 10000 && cyc < 40000) begin
            if (!pending && ($urandom % 4 != 0)) begin
                in_valid = 1'b1; in_int = rand_operand();
                is_signed = 1'($urandom % 2); rnd_mode = 1'($urandom % 2);
                pending = 1'b1;
            end
            out_ready = ($urandom % 3 != 0);
            #1;
            acc = int'(in_valid && in_ready);
            tick();
            cyc++;
            if (acc != 0) begin
                sent++;
                pending = 1'b0;
                in_valid = 1'b0;
            end
        end
        chk("random_sent", 32'(sent), 32'd10000);
        drain();

        // reset with three items in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_int = 32'(5000 + i); is_signed = 1'b1; rnd_mode = 1'b0;
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_float", 32'(float_out), 32'd0);
        chk("rst_exc", 32'(exceptions), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rst_no_ghost", 32'(out_valid), 32'd0);
        end
        push(32'd7, 1'b1, 1'b0);
        push(32'hFFFF_FFF9, 1'b1, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
